// File: rtl/ser_pkg.sv
// Shared one-hot state encoding for the serializer and the downstream detector's encoding check.
package ser_pkg;

    localparam int unsigned ST_IDLE_IDX  = 0;
    localparam int unsigned ST_SHIFT_IDX = 1;
    localparam int unsigned ST_GAP_IDX   = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        GAP   = 3'b100
    } ser_state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: valid/ready word intake, MSB/LSB-first shifting and optional idle gap.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [GCW-1:0] GAP_ONE  = GCW'(1);
    localparam logic [GCW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GCW'(GAP_CYCLES - 1) : GCW'(0);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic             dout_q, dout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             last_bit_s;
    logic             accept_s;

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign last_bit_s = state_q[ST_SHIFT_IDX] && (bit_cnt_q == LAST_BIT);
    // Back-to-back acceptance on the last bit only when no gap follows the word.
    assign data_ready = rst_n && (state_q[ST_IDLE_IDX] || (last_bit_s && (GAP_CYCLES == 0)));
    assign accept_s   = data_valid && data_ready;

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d   = SHIFT;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!last_bit_s) begin
                    shreg_d   = shift_once(shreg_q);
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end else if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (accept_s) begin
                    state_d   = SHIFT;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are derived from the next state so they line up with the registered state.
        dout_d = state_d[ST_SHIFT_IDX] ? head_bit(shreg_d) : IDLE_BIT;
        done_d = state_d[ST_SHIFT_IDX] && (bit_cnt_d == LAST_BIT);
        busy_d = state_d[ST_SHIFT_IDX] || state_d[ST_GAP_IDX];
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= IDLE_BIT;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(state_q));
    a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> busy_q);
    a_shreg_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (!data_ready && !state_q[ST_SHIFT_IDX]) |=> $stable(shreg_q));

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: four serializer configurations against a cycle-timeline reference model.
module tb_bit_serializer;

    localparam int   CFG_W   [4] = '{8, 8, 8, 4};
    localparam int   CFG_MSB [4] = '{1, 1, 0, 1};
    localparam int   CFG_GAP [4] = '{0, 2, 0, 1};
    localparam logic CFG_IDLE[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk;
    logic       rst_n;
    logic [7:0] din  [4];
    logic       dv   [4];
    logic       rdy  [4];
    logic       dout [4];
    logic       busy [4];
    logic       done [4];

    int n_asserts;
    int n_fail;
    logic [7:0] wq[$];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .dout(dout[0]), .busy(busy[0]), .done(done[0]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .dout(dout[1]), .busy(busy[1]), .done(done[1]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0), .IDLE_BIT(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(din[2]), .data_valid(dv[2]),
        .data_ready(rdy[2]), .dout(dout[2]), .busy(busy[2]), .done(done[2]));
    bit_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(1), .IDLE_BIT(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .data_in(din[3][3:0]), .data_valid(dv[3]),
        .data_ready(rdy[3]), .dout(dout[3]), .busy(busy[3]), .done(done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int d, input int c, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d: got %b expected %b", tag, d, c, obs, exp);
        end
    endtask

    // Drives the words in wq into DUT d and checks every cycle against a timeline built
    // from acceptance times: bit k at accept+1+k, done at accept+W, busy through the gap.
    task automatic run_stream(input int d, input bit hold);
        int   w, g, m, next_free, last_cyc;
        logic ib, v;
        logic [7:0] wd;
        logic e_dout [512];
        bit   e_done [512];
        bit   e_busy [512];
        w = CFG_W[d]; g = CFG_GAP[d]; m = CFG_MSB[d]; ib = CFG_IDLE[d];
        for (int i = 0; i < 512; i++) begin
            e_dout[i] = ib; e_done[i] = 1'b0; e_busy[i] = 1'b0;
        end
        next_free = 0;
        last_cyc  = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            chk("dout",  d, c, dout[d], e_dout[c]);
            chk("done",  d, c, done[d], e_done[c]);
            chk("busy",  d, c, busy[d], e_busy[c]);
            chk("ready", d, c, rdy[d],  (c >= next_free) ? 1'b1 : 1'b0);
            if (wq.size() == 0 && c >= last_cyc) break;
            v = (wq.size() > 0) && (hold || ($urandom_range(0, 1) == 1));
            dv[d]  = v;
            din[d] = v ? wq[0] : 8'($urandom);
            if (v && c >= next_free) begin
                wd = wq.pop_front();
                for (int k = 0; k < w; k++) e_dout[c + 1 + k] = (m != 0) ? wd[w - 1 - k] : wd[k];
                e_done[c + w] = 1'b1;
                for (int j = c + 1; j <= c + w + g; j++) e_busy[j] = 1'b1;
                next_free = (g == 0) ? c + w : c + w + g + 1;
                last_cyc  = c + w + g + 1;
            end
        end
        dv[d] = 1'b0;
        n_asserts++;
        assert (wq.size() == 0) else begin
            n_fail++;
            $error("FAIL drain dut%0d: %0d words left, expected 0", d, wq.size());
        end
        wq.delete();
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dv[i] = 1'b0; din[i] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_dout",  i, -1, dout[i], CFG_IDLE[i]);
            chk("rst_busy",  i, -1, busy[i], 1'b0);
            chk("rst_done",  i, -1, done[i], 1'b0);
            chk("rst_ready", i, -1, rdy[i],  1'b0);
        end
        rst_n = 1'b1;

        // Directed cases from the test plan.
        wq = '{8'hA5};              run_stream(0, 1'b1);
        wq = '{8'hF0, 8'h0F};       run_stream(0, 1'b1);
        wq = '{8'hFF, 8'hFF};       run_stream(1, 1'b1);
        wq = '{8'h01};              run_stream(2, 1'b1);
        wq = '{8'h0D};              run_stream(3, 1'b1);

        // Asynchronous reset while bit index 2 of 0xA5 (a one) is on the line.
        dv[0] = 1'b1; din[0] = 8'hA5;
        @(negedge clk);
        dv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_dout_pre", 0, -1, dout[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_dout_rst",  0, -1, dout[0], 1'b0);
        chk("mid_busy_rst",  0, -1, busy[0], 1'b0);
        chk("mid_done_rst",  0, -1, done[0], 1'b0);
        chk("mid_ready_rst", 0, -1, rdy[0],  1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_done_hold", 0, -1, done[0], 1'b0);
        rst_n = 1'b1;
        #1;
        chk("mid_ready_rel", 0, -1, rdy[0], 1'b1);
        wq = '{8'h3C};              run_stream(0, 1'b1);

        // Random words with random and held valid on every configuration.
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 2; r++) begin
                for (int i = 0; i < 6; i++) wq.push_back(8'($urandom_range(0, (1 << CFG_W[d]) - 1)));
                run_stream(d, r[0]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
